// File: rtl/signed_shift_divider_if.sv
// rtl/signed_shift_divider_if.sv - handshake and operand/result bundle for signed_shift_divider
interface signed_shift_divider_if #(
    parameter int N = 32
) ();
    logic         en;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output en, start, x, y,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  en, start, x, y,
        output q, r, busy, done, div_by_zero
    );
endinterface

// File: rtl/signed_shift_divider.sv
// rtl/signed_shift_divider.sv - sequential restoring divider, one quotient bit per enabled clock
// Two's-complement operands when SIGNED_DIV_EN is defined, unsigned otherwise.
module signed_shift_divider #(
    parameter int N = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    signed_shift_divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  ymag_q, ymag_d;
    logic [N-1:0]  qsr_q, qsr_d;
    logic [N:0]    p_q, p_d;
    logic          quo_neg_q, quo_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;

    logic          x_neg, y_neg;
    logic [N-1:0]  x_mag, y_mag;
    logic [N:0]    p_sh;
    logic [N+1:0]  diff;
    logic [N-1:0]  q_fix, r_fix;

`ifdef SIGNED_DIV_EN
    assign x_neg = x_q[N-1];
    assign y_neg = y_q[N-1];
`else
    assign x_neg = 1'b0;
    assign y_neg = 1'b0;
`endif

    // Negating the most-negative value yields 2^(N-1), which is its correct unsigned magnitude.
    assign x_mag = x_neg ? (~x_q + ONE) : x_q;
    assign y_mag = y_neg ? (~y_q + ONE) : y_q;

    assign p_sh  = {p_q[N-1:0], qsr_q[N-1]};
    assign diff  = {1'b0, p_sh} - {2'b00, ymag_q};
    assign q_fix = quo_neg_q ? (~qsr_q + ONE) : qsr_q;
    assign r_fix = rem_neg_q ? (~p_q[N-1:0] + ONE) : p_q[N-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        ymag_d    = ymag_q;
        qsr_d     = qsr_q;
        p_d       = p_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        q_d       = q_q;
        r_d       = r_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                quo_neg_d = x_neg ^ y_neg;
                rem_neg_d = x_neg;
                p_d       = '0;
                qsr_d     = x_mag;
                ymag_d    = y_mag;
                zero_d    = (y_q == '0);
                cnt_d     = CNT_LAST;
                busy_d    = 1'b1;
                state_d   = S_ITER;
            end
            S_ITER: begin
                // A clear top bit of diff means the trial subtraction did not borrow.
                if (!diff[N+1]) begin
                    p_d   = diff[N:0];
                    qsr_d = {qsr_q[N-2:0], 1'b1};
                end else begin
                    p_d   = p_sh;
                    qsr_d = {qsr_q[N-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (zero_q) begin
                    q_d  = '1;
                    r_d  = x_q;
                    dz_d = 1'b1;
                end else begin
                    q_d  = q_fix;
                    r_d  = r_fix;
                    dz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ymag_q    <= '0;
            qsr_q     <= '0;
            p_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else if (bus.en) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ymag_q    <= ymag_d;
            qsr_q     <= qsr_d;
            p_q       <= p_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            q_q       <= q_d;
            r_q       <= r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_signed_shift_divider.sv
// tb/tb_signed_shift_divider.sv - directed bench with cycle-level reference model for signed_shift_divider
module tb_signed_shift_divider;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    signed_shift_divider_if #(.N(N)) bus ();

    signed_shift_divider #(.N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

`ifdef SIGNED_DIV_EN
    localparam logic [31:0] E2Q = 32'h00000001, E2R = 32'hFFFFFFFD;
    localparam logic [31:0] E3Q = 32'hFFFFFFFD, E3R = 32'h00000001;
    localparam logic [31:0] E4Q = 32'hFFFFFFFE, E4R = 32'h00000000;
    localparam logic [31:0] E6Q = 32'h80000000, E6R = 32'h00000000;
`else
    localparam logic [31:0] E2Q = 32'h00000000, E2R = 32'hFFFFFFF9;
    localparam logic [31:0] E3Q = 32'h00000000, E3R = 32'h00000007;
    localparam logic [31:0] E4Q = 32'h3FFFFFFE, E4R = 32'h00000000;
    localparam logic [31:0] E6Q = 32'h00000000, E6R = 32'h80000000;
`endif

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count enabled edges since acceptance; the result lands N+2 edges after acceptance.
    int          phase = 0;
    logic [31:0] mx = '0, my = '0, m_q = '0, m_r = '0;
    logic        m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0; m_q = '0; m_r = '0; m_done = 1'b0; m_dz = 1'b0;
        end else if (bus.en) begin
            m_done = 1'b0;
            if (phase == 0) begin
                if (bus.start) begin
                    mx = bus.x; my = bus.y; phase = 1;
                end
            end else begin
                phase++;
                if (phase == N + 3) begin
                    phase  = 0;
                    m_done = 1'b1;
                    if (my == 0) begin
                        m_q = '1; m_r = mx; m_dz = 1'b1;
                    end else begin
                        m_dz = 1'b0;
`ifdef SIGNED_DIV_EN
                        if (mx == 32'h80000000 && my == 32'hFFFFFFFF) begin
                            m_q = 32'h80000000; m_r = '0;
                        end else begin
                            m_q = 32'($signed(mx) / $signed(my));
                            m_r = 32'($signed(mx) % $signed(my));
                        end
`else
                        m_q = mx / my;
                        m_r = mx % my;
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle{busy,done,dz,q,r}",
            {29'd0, bus.busy, bus.done, bus.div_by_zero, bus.q, bus.r},
            {29'd0, (phase >= 2), m_done, m_dz, m_q, m_r});
    end

    // mode: 0 plain, 1 extra start mid-op, 2 en low 5 cycles, 3 reset at cycle 10
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int exp_lat, input int mode);
        int cnt = 0;
        int busy_cnt = 0;
        int extra = 0;
        bit got = 0;
        @(negedge clk);
        bus.x = x; bus.y = y; bus.start = 1'b1;
        while (cnt < 200 && !got) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                bus.start = 1'b0;
                bus.x = x ^ 32'h5A5A_0F0F;
                bus.y = y ^ 32'h0000_0003;
            end
            if (mode == 1 && cnt == 10) bus.start = 1'b1;
            if (mode == 1 && cnt == 11) bus.start = 1'b0;
            if (mode == 2 && cnt == 10) bus.en = 1'b0;
            if (mode == 2 && cnt == 15) bus.en = 1'b1;
            if (mode == 3 && cnt == 10) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_q", {64'd0, bus.q}, 96'd0);
                chk("rst_mid_r", {64'd0, bus.r}, 96'd0);
                chk("rst_mid_flags", {93'd0, bus.busy, bus.done, bus.div_by_zero}, 96'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (bus.done) got = 1;
            else if (bus.busy) busy_cnt++;
        end
        chk("done_seen", {95'd0, got}, 96'd1);
        chk("latency", 96'(cnt - 1), 96'(exp_lat));
        chk("q", {64'd0, bus.q}, {64'd0, eq});
        chk("r", {64'd0, bus.r}, {64'd0, er});
        chk("div_by_zero", {95'd0, bus.div_by_zero}, {95'd0, edz});
        if (mode == 0) chk("busy_cycles", 96'(busy_cnt), 96'(N + 1));
        if (mode == 1) begin
            repeat (40) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            chk("extra_done", 96'(extra), 96'd0);
        end
    endtask

    initial begin
        bus.en = 1'b1; bus.start = 1'b0; bus.x = '0; bus.y = '0;
        repeat (3) @(negedge clk);
        chk("reset_q", {64'd0, bus.q}, 96'd0);
        chk("reset_r", {64'd0, bus.r}, 96'd0);
        chk("reset_flags", {93'd0, bus.busy, bus.done, bus.div_by_zero}, 96'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd8, 32'd2, 32'd4, 32'd0, 1'b0, 34, 0);
        run_op(-32'sd7, -32'sd4, E2Q, E2R, 1'b0, 34, 0);
        run_op(32'd7, -32'sd2, E3Q, E3R, 1'b0, 34, 0);
        run_op(-32'sd8, 32'd4, E4Q, E4R, 1'b0, 34, 0);
        run_op(32'd524290, 32'd0, 32'hFFFFFFFF, 32'd524290, 1'b1, 34, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, E6Q, E6R, 1'b0, 34, 1);
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 39, 2);
        run_op(32'd5000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 3);
        repeat (3) @(negedge clk);
        run_op(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 34, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
